// File: rtl/pu_master_spi.sv
// pu_master_spi: NITTA processing unit acting as an SPI master (mode 0).
//
// Words written from the PU bus during a computational cycle form one
// outgoing frame of FRAME_WORDS words. When the next signal_cycle arrives
// with the engine idle, that frame is shifted out on mosi (word 0 first,
// MSB first) while an equal-length frame is captured from miso. The
// captured frame becomes readable on the PU bus after the following
// accepted signal_cycle. The tx and rx sides are both double-buffered.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   signal_cycle        one-clk pulse starting a computational cycle
//   signal_wr, data_in  write strobe and word to queue for transmission
//   attr_in             unused
//   signal_oe           read strobe; data_out/attr_out are zero when low
//   data_out, attr_out  received word; attr[0]=invalid, attr[1]=overrun
//   flag_busy           high while an SPI frame is in progress
//   mosi, miso, sclk    SPI data and clock (CPOL=0, CPHA=0)
//   cs                  active-low chip select
module pu_master_spi #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ATTR_WIDTH      = 4,
    parameter int                    FRAME_WORDS     = 2,
    parameter int                    SCLK_HALFPERIOD = 1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD    = 32'hCCCCCCCC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_cycle,
    input  logic                  signal_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  flag_busy,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  cs
);

    localparam int NBITS = FRAME_WORDS * DATA_WIDTH;
    localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int HW    = (SCLK_HALFPERIOD > 1) ? $clog2(SCLK_HALFPERIOD) : 1;
    localparam int PW    = $clog2(FRAME_WORDS + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

    state_t state, state_next;

    logic [HW-1:0]         hp_cnt;
    logic                  hp_done;
    logic                  phase;      // 0: sclk low half, 1: sclk high half
    logic [BW-1:0]         bit_cnt;
    logic                  last_bit;
    logic                  accept;
    logic                  busy_cycle;
    logic                  rise_edge;
    logic                  fall_edge;
    logic                  frame_done;

    logic [DATA_WIDTH-1:0] tx_wr [FRAME_WORDS];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [NBITS-1:0]      tx_shift;
    logic [NBITS-1:0]      rx_shift;
    logic [NBITS-1:0]      rx_pending;
    logic [NBITS-1:0]      rx_out;
    logic                  rx_valid;
    logic                  ever_done;
    logic                  overrun;

    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_hit;
    logic                  attr_unused;

    assign attr_unused = ^attr_in;

    assign hp_done    = (hp_cnt == HW'(SCLK_HALFPERIOD - 1));
    assign last_bit   = (bit_cnt == BW'(NBITS - 1));
    assign accept     = signal_cycle && (state == IDLE);
    assign busy_cycle = signal_cycle && (state != IDLE);
    assign rise_edge  = (state == SHIFT) && hp_done && !phase;
    assign fall_edge  = (state == SHIFT) && hp_done && phase;
    assign frame_done = (state == STOP) && hp_done;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (signal_cycle)                   state_next = START;
            START:   if (hp_done)                        state_next = SHIFT;
            SHIFT:   if (hp_done && phase && last_bit)   state_next = STOP;
            STOP:    if (hp_done)                        state_next = IDLE;
            default:                                     state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Outputs decode the state register directly, so an asynchronous reset
    // releases cs and parks sclk without waiting for a clock edge.
    always_comb begin
        cs        = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        flag_busy = 1'b0;
        if (state != IDLE) begin
            cs        = 1'b0;
            flag_busy = 1'b1;
            mosi      = tx_shift[NBITS-1];
        end
        if (state == SHIFT) sclk = phase;
    end

    // ---------------- bit timing ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hp_cnt  <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            hp_cnt  <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            hp_cnt <= hp_done ? '0 : hp_cnt + 1'b1;
            if (rise_edge) phase <= 1'b1;
            if (fall_edge) begin
                phase   <= 1'b0;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // ---------------- shift registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_pending <= '0;
            ever_done  <= 1'b0;
        end else begin
            if (accept) begin
                for (int unsigned i = 0; i < FRAME_WORDS; i++)
                    tx_shift[(FRAME_WORDS-1-i)*DATA_WIDTH +: DATA_WIDTH] <= tx_wr[i];
            end else if (fall_edge) begin
                tx_shift <= {tx_shift[NBITS-2:0], 1'b0};
            end
            if (rise_edge) rx_shift <= {rx_shift[NBITS-2:0], miso};
            if (frame_done) begin
                rx_pending <= rx_shift;
                ever_done  <= 1'b1;
            end
        end
    end

    // ---------------- PU bus side ----------------
    // A write coinciding with signal_cycle lands in slot 0 after the clear;
    // the later non-blocking assignment to tx_wr[0] overrides the default.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FRAME_WORDS; i++) tx_wr[i] <= DEFAULT_WORD;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overrun  <= 1'b0;
            rx_valid <= 1'b0;
            rx_out   <= '0;
        end else if (signal_cycle) begin
            for (int unsigned i = 0; i < FRAME_WORDS; i++) tx_wr[i] <= DEFAULT_WORD;
            wr_ptr <= '0;
            rd_ptr <= '0;
            if (accept) begin
                rx_out   <= rx_pending;
                rx_valid <= ever_done;
                overrun  <= 1'b0;
            end else if (busy_cycle) begin
                overrun <= 1'b1;
            end
            if (signal_wr) begin
                tx_wr[0] <= data_in;
                wr_ptr   <= PW'(1);
            end
        end else begin
            if (signal_wr) begin
                if (wr_ptr == PTR_MAX) begin
                    overrun <= 1'b1;
                end else begin
                    for (int unsigned i = 0; i < FRAME_WORDS; i++)
                        if (wr_ptr == PW'(i)) tx_wr[i] <= data_in;
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (signal_oe && (rd_ptr != PTR_MAX)) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        rd_word  = '0;
        rd_hit   = 1'b0;
        data_out = '0;
        attr_out = '0;
        for (int unsigned i = 0; i < FRAME_WORDS; i++) begin
            if (rd_ptr == PW'(i)) begin
                rd_word = rx_out[(FRAME_WORDS-1-i)*DATA_WIDTH +: DATA_WIDTH];
                rd_hit  = 1'b1;
            end
        end
        if (signal_oe) begin
            if (rx_valid && rd_hit) data_out    = rd_word;
            else                    attr_out[0] = 1'b1;
            attr_out[1] = overrun;
        end
    end

endmodule

// File: tb/tb_pu_master_spi.sv
module tb_pu_master_spi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signal_cycle = 1'b0;
    logic        signal_wr = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  attr_in = '0;
    logic        signal_oe = 1'b0;
    logic [31:0] data_out;
    logic [3:0]  attr_out;
    logic        flag_busy;
    logic        mosi;
    logic        miso;
    logic        sclk;
    logic        cs;

    int checks = 0;
    int errors = 0;

    // SPI slave model (mode 0): presents bit 63 when cs falls, advances on
    // each falling sclk edge; records mosi on each rising sclk edge.
    logic [63:0] slave_tx = '0;
    logic [6:0]  idx = '0;
    logic [63:0] mosi_cap = '0;
    int          rise_cnt = 0;
    int          busy_clks = 0;

    always #5 clk = ~clk;

    pu_master_spi #(
        .DATA_WIDTH(32),
        .ATTR_WIDTH(4),
        .FRAME_WORDS(2),
        .SCLK_HALFPERIOD(1),
        .DEFAULT_WORD(32'hCCCCCCCC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .signal_cycle(signal_cycle),
        .signal_wr(signal_wr),
        .data_in(data_in),
        .attr_in(attr_in),
        .signal_oe(signal_oe),
        .data_out(data_out),
        .attr_out(attr_out),
        .flag_busy(flag_busy),
        .mosi(mosi),
        .miso(miso),
        .sclk(sclk),
        .cs(cs)
    );

    always @(negedge sclk or posedge cs) begin
        if (cs) idx <= '0;
        else    idx <= idx + 7'd1;
    end

    assign miso = (!cs && !idx[6]) ? slave_tx[~idx[5:0]] : 1'b0;

    always @(posedge sclk) begin
        mosi_cap <= {mosi_cap[62:0], mosi};
        rise_cnt <= rise_cnt + 1;
    end

    always @(posedge clk) if (flag_busy) busy_clks <= busy_clks + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cycle();
        signal_cycle = 1'b1;
        tick();
        signal_cycle = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        signal_wr = 1'b1;
        data_in   = w;
        tick();
        signal_wr = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [31:0] exp_d, input logic [3:0] exp_a);
        signal_oe = 1'b1;
        #1;
        check({tag, " data"}, {32'd0, data_out}, {32'd0, exp_d});
        check({tag, " attr"}, {60'd0, attr_out}, {60'd0, exp_a});
        tick();
        signal_oe = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (flag_busy && n < 1000) begin
            tick();
            n++;
        end
        check({tag, " timeout"}, {63'd0, n < 1000}, 64'd1);
    endtask

    task automatic run_frame(input string tag, input logic [63:0] exp_mosi);
        int r0, b0;
        r0 = rise_cnt;
        b0 = busy_clks;
        pulse_cycle();
        wait_idle(tag);
        check({tag, " busy"},  64'(busy_clks - b0), 64'd130);
        check({tag, " rises"}, 64'(rise_cnt - r0),  64'd64);
        check({tag, " mosi"},  mosi_cap, exp_mosi);
        check({tag, " cs"},    {63'd0, cs}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, b0, n;

        // Reset state
        signal_oe = 1'b1;
        #12;
        check("rst cs",        {63'd0, cs},        64'd1);
        check("rst sclk",      {63'd0, sclk},      64'd0);
        check("rst mosi",      {63'd0, mosi},      64'd0);
        check("rst busy",      {63'd0, flag_busy}, 64'd0);
        check("rst data_out",  {32'd0, data_out},  64'd0);
        check("rst attr_out",  {60'd0, attr_out},  64'd1);
        signal_oe = 1'b0;
        #11;
        rst = 1'b1;
        tick();

        // Default frame: nothing written, no prior transaction
        slave_tx = 64'hA0A1A2A3A4A5A6A7;
        run_frame("f1", 64'hCCCCCCCCCCCCCCCC);
        read_word("f1 rd", 32'h0, 4'b0001);

        // Write two words, then a frame; reads return frame 1's capture
        write_word(32'hB0B1B2B3);
        write_word(32'hB4B5B6B7);
        slave_tx = 64'h1122334455667788;
        run_frame("f2", 64'hB0B1B2B3B4B5B6B7);
        #1;
        check("oe low data", {32'd0, data_out}, 64'd0);
        check("oe low attr", {60'd0, attr_out}, 64'd0);
        tick();
        read_word("f2 rd0", 32'hA0A1A2A3, 4'b0000);
        read_word("f2 rd1", 32'hA4A5A6A7, 4'b0000);
        read_word("f2 rd2", 32'h00000000, 4'b0001);

        // Overrun: third write is dropped
        write_word(32'h11110001);
        write_word(32'h22220002);
        write_word(32'h33330003);
        read_word("ovr rd", 32'h0, 4'b0011);
        slave_tx = 64'h0F0E0D0C0B0A0908;
        run_frame("f3", 64'h1111000122220002);
        read_word("f3 rd0", 32'h11223344, 4'b0000);

        // Cycle pulse 20 clks into a frame
        slave_tx = 64'hDEADBEEF01234567;
        r0 = rise_cnt;
        b0 = busy_clks;
        pulse_cycle();
        read_word("f4 rd0", 32'h0F0E0D0C, 4'b0000);
        repeat (18) tick();
        pulse_cycle();
        wait_idle("f4");
        check("f4 busy",  64'(busy_clks - b0), 64'd130);
        check("f4 rises", 64'(rise_cnt - r0),  64'd64);
        check("f4 mosi",  mosi_cap, 64'hCCCCCCCCCCCCCCCC);
        repeat (5) tick();
        check("f4 no restart busy", 64'(busy_clks - b0), 64'd130);
        check("f4 no restart cs",   {63'd0, cs}, 64'd1);
        read_word("f4 rd after", 32'h0F0E0D0C, 4'b0010);

        // Asynchronous reset at bit 10
        r0 = rise_cnt;
        pulse_cycle();
        n = 0;
        while ((rise_cnt - r0) < 10 && n < 1000) begin
            tick();
            n++;
        end
        check("f5 reach bit10", {63'd0, n < 1000}, 64'd1);
        check("f5 sclk pre",    {63'd0, sclk}, 64'd1);
        rst = 1'b0;
        #1;
        check("f5 async cs",   {63'd0, cs},        64'd1);
        check("f5 async sclk", {63'd0, sclk},      64'd0);
        check("f5 async busy", {63'd0, flag_busy}, 64'd0);
        check("f5 async mosi", {63'd0, mosi},      64'd0);
        #1;
        rst = 1'b1;
        tick();
        slave_tx = 64'h5555AAAA5555AAAA;
        run_frame("f6", 64'hCCCCCCCCCCCCCCCC);
        read_word("f6 rd", 32'h0, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_master_spi.md
Name: pu_master_spi

Overview:
- NITTA processing unit acting as SPI master; the initiator-side counterpart of the slave SPI PU, talking to an external SPI slave device.
- Each computational cycle, words written from the PU bus form one outgoing frame; the frame is shifted out on MOSI while an equal-length frame is captured from MISO.
- The captured frame becomes readable on the PU bus after the next signal_cycle.
- Double-buffered on both the tx and rx sides, so bus traffic and SPI traffic overlap.

Parameters:
- DATA_WIDTH, 32, PU bus word width; also the SPI word width.
- ATTR_WIDTH, 4, attribute width (bit 0 = invalid, bit 1 = error, others 0).
- FRAME_WORDS, 2, words per SPI transaction in each direction.
- SCLK_HALFPERIOD, 1, clk cycles per sclk half-period (>=1).
- DEFAULT_WORD, 32'hCCCCCCCC, transmitted for frame slots not written this cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- signal_cycle  in  1  one-clk pulse marking the start of a computational cycle.
- signal_wr  in  1  write strobe; data_in is captured into the next tx slot.
- data_in  in  DATA_WIDTH  word to send.
- attr_in  in  ATTR_WIDTH  ignored.
- signal_oe  in  1  read strobe; presents the next received word.
- data_out  out  DATA_WIDTH  received word; 0 when signal_oe is low (OR-bus).
- attr_out  out  ATTR_WIDTH  attributes; 0 when signal_oe is low.
- flag_busy  out  1  high while an SPI transaction is in progress.
- mosi  out  1  master out.
- miso  in  1  master in.
- sclk  out  1  SPI clock (mode 0: CPOL=0, CPHA=0).
- cs  out  1  chip select, active-low.

Behaviour:
- Reset (rst=0, async):
  - cs=1, sclk=0, mosi=0, flag_busy=0.
  - FSM returns to IDLE, including when reset arrives mid-transaction; the frame is abandoned and cs rises immediately.
  - Pointers=0, overrun=0, rx_valid=0, all tx slots = DEFAULT_WORD.
- Write side:
  - signal_wr stores data_in into tx_wr[wr_ptr], then wr_ptr++.
  - A write when wr_ptr==FRAME_WORDS is dropped and sets overrun.
- Cycle accept (signal_cycle=1 while FSM in IDLE):
  - tx_wr copies into tx_shift; tx_wr slots reset to DEFAULT_WORD; wr_ptr=0.
  - rx_pending copies into rx_out; rx_valid is set if a transaction has ever completed; rd_ptr=0; overrun=0.
  - FSM enters START on the next clk.
  - signal_wr in the same clk as signal_cycle lands in slot 0 of the new cycle, i.e. after the clear.
- Cycle while busy (FSM not IDLE):
  - No new transaction is started; the transaction in flight completes normally.
  - tx_wr is discarded (reset to DEFAULT_WORD), wr_ptr=0, rd_ptr=0.
  - rx_out is unchanged; overrun is set.
- FSM states and transitions:
  - IDLE -> START on an accepted cycle: cs=0, flag_busy=1, mosi = MSB of word 0; wait SCLK_HALFPERIOD clks.
  - SHIFT: per bit, hold sclk=0 for HP clks, then sclk=1 for HP clks.
    - miso is sampled on the clk where sclk rises.
    - On the falling edge the next bit is driven on mosi.
    - Words go in order 0..FRAME_WORDS-1, MSB first.
  - After FRAME_WORDS*DATA_WIDTH bits -> STOP: sclk=0, hold HP clks -> IDLE with cs=1, mosi=0, flag_busy=0.
  - Total cs-low time = HP*(2*FRAME_WORDS*DATA_WIDTH + 2) clks.
  - On entry to IDLE, the captured bits (first received bit = MSB of word 0) are written into rx_pending.
- Read side (combinational from signal_oe and rd_ptr):
  - If rx_valid and rd_ptr<FRAME_WORDS: data_out=rx_out[rd_ptr], attr_out[0]=0.
  - Otherwise: data_out=0, attr_out[0]=1.
  - attr_out[1]=overrun.
  - rd_ptr++ on each clk with signal_oe high, saturating at FRAME_WORDS.
- Simultaneous signal_wr and signal_oe in one clk are both honoured.

Test Plan:
- Reset value check: hold rst=0 -> cs=1, sclk=0, mosi=0, flag_busy=0; signal_oe gives data_out=0, attr_out=4'b0001.
- Default frame: cycle with no writes; slave model returns 64'hA0A1A2A3A4A5A6A7 -> mosi carries 64'hCCCCCCCCCCCCCCCC MSB-first; flag_busy high for exactly 130 clks (HP=1); 64 sclk rising edges.
- Write then read: write 32'hB0B1B2B3 and 32'hB4B5B6B7, then cycle -> mosi carries B0B1B2B3B4B5B6B7. Then oe x3 -> A0A1A2A3/attr 0, A4A5A6A7/attr 0, then 0/attr 4'b0001.
- Overrun: three writes in one cycle -> third is dropped; attr_out[1]=1 on reads until the next accepted cycle.
- Cycle during transaction: pulse cycle 20 clks after start -> cs-low length unchanged; no second transaction; rx_out unchanged; attr_out[1]=1.
- Async reset mid-frame: rst low at bit 10 -> cs=1, sclk=0 in the same cycle without waiting for clk; the next accepted cycle sends a full DEFAULT frame.
